// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: data width, default
// geometry, latency bounds and the responder state encoding.
package dmem_pkg;

    // Width of one memory word and of the request/response data buses.
    localparam int DATA_W = 32;

    // Default word-address width; the array holds 2**ADDR_W words.
    localparam int DEFAULT_ADDR_W = 8;

    // Default number of wait cycles between accept and access.
    localparam int DEFAULT_LATENCY = 2;

    // The wait counter is 4 bits wide, so the latency tops out at 15.
    localparam int CNT_W       = 4;
    localparam int MAX_LATENCY = (1 << CNT_W) - 1;

    // Responder states: idle and accepting, counting down, presenting a response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, combinational read. Contents
// are not touched by reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Word write on the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory path. One request at a time is
// accepted, held for LATENCY wait cycles, then the word access is performed
// and the result is presented on the response channel until taken.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready are both high. The requester keeps req_valid and the
// request fields steady until that edge; the responder keeps rsp_valid,
// rsp_rdata and rsp_err steady from the edge rsp_valid rises until the
// transfer edge.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    // Elaboration-time guard on the parameters.
    if (LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("dmem_responder: LATENCY=%0d outside 0..%0d", LATENCY, MAX_LATENCY);
    end
    if (ADDR_W < 1 || ADDR_W > 31) begin : g_bad_addr_w
        $error("dmem_responder: ADDR_W=%0d outside 1..31", ADDR_W);
    end

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

    // State is kept as a named signal so checkers can bind to it directly.
    dmem_state_e       state;
    logic [CNT_W-1:0]  cnt;

    // Request captured at the accept edge; the requester may change its
    // bus as soon as the accept has happened.
    logic              cap_we;
    logic [31:0]       cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic              in_range;
    logic              access;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Any address bit at or above ADDR_W set means the word does not exist.
    assign in_range = (cap_addr >> ADDR_W) == 32'd0;

    // The access cycle is the last WAIT cycle, when the counter has run out.
    assign access = (state == WAIT) && (cnt == '0);

    // Out-of-range stores are dropped rather than aliased onto the array.
    assign mem_we = access && cap_we && in_range;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (cap_addr[ADDR_W-1:0]),
        .wdata (cap_wdata),
        .rdata (mem_rdata)
    );

    // Responder FSM: accept, count down, access, then hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cnt       <= LAT_CNT;
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // Access cycle: the array write (if any) lands on
                        // this same edge through mem_we.
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                        if (!in_range) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                        end else if (cap_we) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b0;
                        end else begin
                            rsp_rdata <= mem_rdata;
                            rsp_err   <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    // rsp_rdata/rsp_err keep their values after the
                    // transfer; only rsp_valid drops.
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
